// File: rtl/lcd_bus_decoder.sv
// Responder for an HD44780-style character-LCD bus: synchronizes the bus, latches
// transfers on the falling edge of E, and keeps a readable 2x16 shadow DDRAM.
module lcd_bus_decoder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CLEAR_CHAR  = 8'h20,
  parameter int         ROW_LEN     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_index,
  output logic [7:0] rd_char,
  output logic [4:0] cursor_index,
  output logic       cursor_vis,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic [2:0] func_bits,
  output logic       busy,
  output logic       cmd_stb,
  output logic       overrun,
  output logic [1:0] fsm_state
);

  localparam int DEPTH = 2 * ROW_LEN;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, CLEAR = 2'd2} state_t;

  state_t      state;
  logic [10:0] sync_q [SYNC_STAGES];
  logic        e_prev;
  logic        rs_s, rw_s, e_s;
  logic [7:0]  data_s;
  logic        xfer;

  logic        cmd_rs, pend_rs, pend_valid, cgram_mode;
  logic [7:0]  cmd_data, pend_data;
  logic [6:0]  ac;
  logic [4:0]  sweep_idx;
  logic [7:0]  ddram [DEPTH];
  logic [5:0]  cur_map;
  logic        exec_clear, sweep_last, take_pend, direct, to_pend;

  // {visible, index} for an address-counter value on the 2-line map.
  function automatic logic [5:0] map_ac(input logic [6:0] a);
    if (a[6:4] == 3'b000) return {2'b10, a[3:0]};
    if (a[6:4] == 3'b100) return {2'b11, a[3:0]};
    return 6'b0;
  endfunction

  // Out-of-line addresses snap to the start of the next line regardless of direction.
  function automatic logic [6:0] step_ac(input logic [6:0] a, input logic inc);
    if (a >= 7'h28 && a <= 7'h3F) return 7'h40;
    if (a >= 7'h68) return 7'h00;
    if (inc) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h40) return 7'h27;
    if (a == 7'h00) return 7'h67;
    return a - 7'd1;
  endfunction

  assign {rs_s, rw_s, e_s, data_s} = sync_q[SYNC_STAGES-1];
  // Read cycles are not transfers: they neither strobe nor occupy the pending slot.
  assign xfer       = e_prev & ~e_s & ~rw_s;
  assign cur_map    = map_ac(ac);
  assign cursor_vis = cur_map[5];
  assign cursor_index = cur_map[4:0];
  assign busy       = (state == CLEAR);
  assign fsm_state  = state;

  assign exec_clear = !cmd_rs && (cmd_data == 8'h01);
  assign sweep_last = (sweep_idx == 5'(DEPTH - 1));
  assign take_pend  = pend_valid && ((state == IDLE) ||
                                     (state == EXEC && !exec_clear) ||
                                     (state == CLEAR && sweep_last));
  assign direct     = (state == IDLE) && !pend_valid && xfer;
  assign to_pend    = xfer && !direct;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      e_prev <= 1'b0;
    end else begin
      sync_q[0] <= {lcd_rs, lcd_rw, lcd_e, lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      e_prev <= e_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cmd_rs     <= 1'b0;
      cmd_data   <= 8'h00;
      pend_rs    <= 1'b0;
      pend_data  <= 8'h00;
      pend_valid <= 1'b0;
      cgram_mode <= 1'b0;
      ac         <= 7'h00;
      sweep_idx  <= 5'd0;
      disp_on    <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      entry_inc  <= 1'b1;
      func_bits  <= 3'b011;
      cmd_stb    <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ddram[i] <= CLEAR_CHAR;
    end else begin
      cmd_stb <= 1'b0;

      if (to_pend) begin
        if (pend_valid && !take_pend) begin
          overrun <= 1'b1;
        end else begin
          pend_rs    <= rs_s;
          pend_data  <= data_s;
          pend_valid <= 1'b1;
        end
      end else if (take_pend) begin
        pend_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (take_pend) begin
            cmd_rs   <= pend_rs;
            cmd_data <= pend_data;
            cmd_stb  <= 1'b1;
            state    <= EXEC;
          end else if (direct) begin
            cmd_rs   <= rs_s;
            cmd_data <= data_s;
            cmd_stb  <= 1'b1;
            state    <= EXEC;
          end
        end

        EXEC: begin
          if (cmd_rs) begin
            if (!cgram_mode) begin
              if (cur_map[5]) ddram[cur_map[4:0]] <= cmd_data;
              ac <= step_ac(ac, entry_inc);
            end
          end else begin
            casez (cmd_data)
              8'b1???????: begin ac <= cmd_data[6:0]; cgram_mode <= 1'b0; end
              8'b01??????: cgram_mode <= 1'b1;
              8'b001?????: func_bits <= cmd_data[4:2];
              8'b0001????: if (!cmd_data[3]) ac <= step_ac(ac, cmd_data[2]);
              8'b00001???: {disp_on, cursor_on, blink_on} <= cmd_data[2:0];
              8'b000001??: entry_inc <= cmd_data[1];
              8'b0000001?: begin ac <= 7'h00; cgram_mode <= 1'b0; end
              8'b00000001: begin ac <= 7'h00; entry_inc <= 1'b1; cgram_mode <= 1'b0; end
              default: ;
            endcase
          end
          if (exec_clear) begin
            sweep_idx <= 5'd0;
            state     <= CLEAR;
          end else if (take_pend) begin
            cmd_rs   <= pend_rs;
            cmd_data <= pend_data;
            cmd_stb  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        CLEAR: begin
          ddram[sweep_idx] <= CLEAR_CHAR;
          if (sweep_last) begin
            if (take_pend) begin
              cmd_rs   <= pend_rs;
              cmd_data <= pend_data;
              cmd_stb  <= 1'b1;
              state    <= EXEC;
            end else begin
              state <= IDLE;
            end
          end else begin
            sweep_idx <= sweep_idx + 5'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Readback sees the pre-write contents when a write hits the same index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_char <= 8'h20;
    else      rd_char <= ddram[rd_index];
  end

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Bench for lcd_bus_decoder: directed vector table, clear/overrun sequences and
// random bus traffic compared against an address-map level model of the panel.
module tb_lcd_bus_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] rd_index = 5'd0;
  logic [7:0] rd_char;
  logic [4:0] cursor_index;
  logic       cursor_vis, disp_on, cursor_on, blink_on, entry_inc;
  logic [2:0] func_bits;
  logic       busy, cmd_stb, overrun;
  logic [1:0] fsm_state;

  lcd_bus_decoder dut (
    .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data(lcd_data), .rd_index(rd_index), .rd_char(rd_char),
    .cursor_index(cursor_index), .cursor_vis(cursor_vis), .disp_on(disp_on),
    .cursor_on(cursor_on), .blink_on(blink_on), .entry_inc(entry_inc),
    .func_bits(func_bits), .busy(busy), .cmd_stb(cmd_stb), .overrun(overrun),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int stb_cnt = 0;
  int exp_stb = 0;
  int busy_run = 0;
  int last_busy = 0;

  always @(negedge clk) begin
    if (cmd_stb === 1'b1) stb_cnt++;
    if (busy === 1'b1) busy_run++;
    else if (busy_run != 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
  end

  // Panel model: two 40-cell lines at 0x00 and 0x40, first 16 cells visible.
  logic [7:0] m_ram [32];
  int m_ac;
  bit m_inc, m_d, m_c, m_b, m_cg;
  bit [2:0] m_fb;

  function automatic int m_index(input int a);
    if (a >= 0 && a < 16) return a;
    if (a >= 'h40 && a < 'h50) return 16 + a - 'h40;
    return -1;
  endfunction

  function automatic int m_step(input int a, input bit inc);
    int base, off;
    if (a >= 'h28 && a < 'h40) return 'h40;
    if (a >= 'h68) return 0;
    base = (a >= 'h40) ? 'h40 : 0;
    off  = a - base + (inc ? 1 : -1);
    if (off > 39) return (base == 0) ? 'h40 : 0;
    if (off < 0)  return (base == 0) ? 'h40 + 39 : 39;
    return base + off;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
    m_ac = 0; m_inc = 1; m_d = 0; m_c = 0; m_b = 0; m_cg = 0; m_fb = 3'b011;
  endtask

  task automatic m_apply(input bit rs, input logic [7:0] d);
    int v;
    v = d;
    if (rs) begin
      if (!m_cg) begin
        if (m_index(m_ac) >= 0) m_ram[m_index(m_ac)] = d;
        m_ac = m_step(m_ac, m_inc);
      end
    end else if (v >= 128) begin m_ac = v - 128; m_cg = 0; end
    else if (v >= 64) m_cg = 1;
    else if (v >= 32) m_fb = d[4:2];
    else if (v >= 16) begin if (!d[3]) m_ac = m_step(m_ac, d[2]); end
    else if (v >= 8)  {m_d, m_c, m_b} = d[2:0];
    else if (v >= 4)  m_inc = d[1];
    else if (v >= 2)  begin m_ac = 0; m_cg = 0; end
    else if (v == 1) begin
      for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
      m_ac = 0; m_inc = 1; m_cg = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_edge(input logic rs, input logic rw, input logic [7:0] d);
    @(posedge clk); #1;
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    repeat (3) @(posedge clk);
    #1 lcd_e = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic settle();
    int n;
    n = 0;
    repeat (4) @(posedge clk);
    while (busy === 1'b1 && n < 100) begin @(posedge clk); n++; end
    if (n >= 100) chk("busy_timeout", 1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  // Full transfer: drive, update model, wait for completion.
  task automatic xfer(input bit rs, input logic [7:0] d);
    bus_edge(rs, 1'b0, d);
    m_apply(rs, d);
    exp_stb++;
    settle();
  endtask

  task automatic rd_chk(input int idx, input int exp, input string name);
    @(posedge clk); #1 rd_index = 5'(idx);
    @(posedge clk);
    @(negedge clk);
    chk(name, rd_char, exp);
  endtask

  task automatic chk_model(input string tag);
    int mi;
    mi = m_index(m_ac);
    chk({tag, "_vis"}, cursor_vis, (mi >= 0) ? 1 : 0);
    if (mi >= 0) chk({tag, "_cidx"}, cursor_index, mi);
    chk({tag, "_dcb"}, {disp_on, cursor_on, blink_on}, {m_d, m_c, m_b});
    chk({tag, "_inc"}, entry_inc, m_inc);
    chk({tag, "_func"}, func_bits, m_fb);
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic       vis;
    logic [4:0] idx;
    logic [2:0] dcb;
    logic       inc;
    logic [2:0] fb;
  } vec_t;

  vec_t vecs [20];

  initial begin
    vecs[0]  = '{1'b0, 8'h0C, 1'b1, 5'd0,  3'b100, 1'b1, 3'b011};
    vecs[1]  = '{1'b0, 8'h06, 1'b1, 5'd0,  3'b100, 1'b1, 3'b011};
    vecs[2]  = '{1'b0, 8'h80, 1'b1, 5'd0,  3'b100, 1'b1, 3'b011};
    vecs[3]  = '{1'b1, 8'h48, 1'b1, 5'd1,  3'b100, 1'b1, 3'b011};
    vecs[4]  = '{1'b1, 8'h49, 1'b1, 5'd2,  3'b100, 1'b1, 3'b011};
    vecs[5]  = '{1'b0, 8'h38, 1'b1, 5'd2,  3'b100, 1'b1, 3'b110};
    vecs[6]  = '{1'b0, 8'hC0, 1'b1, 5'd16, 3'b100, 1'b1, 3'b110};
    vecs[7]  = '{1'b0, 8'h8F, 1'b1, 5'd15, 3'b100, 1'b1, 3'b110};
    vecs[8]  = '{1'b0, 8'h04, 1'b1, 5'd15, 3'b100, 1'b0, 3'b110};
    vecs[9]  = '{1'b1, 8'h5A, 1'b1, 5'd14, 3'b100, 1'b0, 3'b110};
    vecs[10] = '{1'b1, 8'h5A, 1'b1, 5'd13, 3'b100, 1'b0, 3'b110};
    vecs[11] = '{1'b0, 8'h06, 1'b1, 5'd13, 3'b100, 1'b1, 3'b110};
    vecs[12] = '{1'b0, 8'hA7, 1'b0, 5'd0,  3'b100, 1'b1, 3'b110};
    vecs[13] = '{1'b1, 8'h33, 1'b1, 5'd16, 3'b100, 1'b1, 3'b110};
    vecs[14] = '{1'b0, 8'h14, 1'b1, 5'd17, 3'b100, 1'b1, 3'b110};
    vecs[15] = '{1'b0, 8'h10, 1'b1, 5'd16, 3'b100, 1'b1, 3'b110};
    vecs[16] = '{1'b0, 8'h1C, 1'b1, 5'd16, 3'b100, 1'b1, 3'b110};
    vecs[17] = '{1'b0, 8'h4A, 1'b1, 5'd16, 3'b100, 1'b1, 3'b110};
    vecs[18] = '{1'b1, 8'h77, 1'b1, 5'd16, 3'b100, 1'b1, 3'b110};
    vecs[19] = '{1'b0, 8'h0F, 1'b1, 5'd16, 3'b111, 1'b1, 3'b110};

    // Reset values
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_char", rd_char, 8'h20);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cmd_stb", cmd_stb, 0);
    #1 rst = 1'b1;
    chk_model("rst");
    for (int i = 0; i < 32; i++) rd_chk(i, 8'h20, "rst_ddram");

    // Directed vectors
    for (int i = 0; i < 20; i++) begin
      xfer(vecs[i].rs, vecs[i].d);
      chk($sformatf("vec%0d_vis", i), cursor_vis, vecs[i].vis);
      if (vecs[i].vis) chk($sformatf("vec%0d_cidx", i), cursor_index, vecs[i].idx);
      chk($sformatf("vec%0d_dcb", i), {disp_on, cursor_on, blink_on}, vecs[i].dcb);
      chk($sformatf("vec%0d_inc", i), entry_inc, vecs[i].inc);
      chk($sformatf("vec%0d_func", i), func_bits, vecs[i].fb);
    end
    rd_chk(0, 8'h48, "vec_rd0");
    rd_chk(1, 8'h49, "vec_rd1");
    rd_chk(15, 8'h5A, "vec_rd15");
    rd_chk(14, 8'h5A, "vec_rd14");
    rd_chk(16, 8'h20, "vec_rd16");
    rd_chk(2, 8'h20, "vec_rd2");

    // Second row fill with one overflow byte past the visible window
    xfer(1'b0, 8'hC0);
    for (int i = 0; i < 17; i++) xfer(1'b1, 8'h41);
    chk("row1_vis", cursor_vis, 0);
    chk("row1_ac", m_ac, 'h51);
    for (int i = 16; i < 32; i++) rd_chk(i, 8'h41, "row1_fill");
    rd_chk(0, 8'h48, "row1_keep0");

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      int r;
      logic [7:0] d;
      r = $urandom_range(0, 11);
      d = 8'($urandom_range(0, 255));
      case (r)
        0, 1, 2, 3: xfer(1'b1, d);
        4: xfer(1'b0, 8'h80 | (d & 8'h7F));
        5: xfer(1'b0, 8'h04 | (d & 8'h03));
        6: xfer(1'b0, 8'h08 | (d & 8'h07));
        7: xfer(1'b0, 8'h10 | (d & 8'h0F));
        8: xfer(1'b0, 8'h20 | (d & 8'h1F));
        9: xfer(1'b0, (d[0]) ? (8'h40 | (d & 8'h3F)) : 8'h02);
        10: xfer(1'b0, ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00);
        default: begin
          bus_edge(d[0], 1'b1, d);
          settle();
        end
      endcase
      chk_model($sformatf("rnd%0d", n));
    end
    for (int i = 0; i < 32; i++) rd_chk(i, m_ram[i], "rnd_ddram");
    chk("rnd_stb_count", stb_cnt, exp_stb);

    // Clear with one queued transfer and one dropped transfer
    xfer(1'b0, 8'h0C);
    xfer(1'b0, 8'h8A);
    xfer(1'b1, 8'h33);
    bus_edge(1'b0, 1'b0, 8'h01);
    bus_edge(1'b1, 1'b0, 8'h5A);
    bus_edge(1'b0, 1'b0, 8'h08);
    m_apply(1'b0, 8'h01);
    m_apply(1'b1, 8'h5A);
    exp_stb += 2;
    settle();
    chk("clr_busy_len", last_busy, 32);
    chk("clr_overrun", overrun, 1);
    chk("clr_disp_kept", disp_on, 1);
    chk("clr_stb_count", stb_cnt, exp_stb);
    chk_model("clr");
    for (int i = 0; i < 32; i++) rd_chk(i, m_ram[i], "clr_ddram");
    rd_chk(0, 8'h5A, "clr_queued");

    // Bus read carrying a clear opcode must do nothing
    bus_edge(1'b0, 1'b1, 8'h01);
    settle();
    chk("read_no_stb", stb_cnt, exp_stb);
    chk("read_no_busy", last_busy, 32);
    rd_chk(0, 8'h5A, "read_keep0");

    // Reset in the middle of a clear sweep
    xfer(1'b0, 8'hCF);
    xfer(1'b1, 8'h77);
    rd_chk(31, 8'h77, "mid_pre31");
    bus_edge(1'b0, 1'b0, 8'h01);
    begin
      int n;
      n = 0;
      while (busy !== 1'b1 && n < 20) begin @(posedge clk); n++; end
      chk("mid_busy_seen", busy, 1);
    end
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_overrun", overrun, 0);
    chk("mid_rd_char", rd_char, 8'h20);
    chk("mid_disp", disp_on, 0);
    chk("mid_inc", entry_inc, 1);
    chk("mid_func", func_bits, 3'b011);
    chk("mid_cidx", cursor_index, 0);
    #1 rst = 1'b1;
    m_reset();
    rd_chk(31, 8'h20, "mid_post31");
    rd_chk(0, 8'h20, "mid_post0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
